bsg_channel_narrow_vr: RTL

Parametrised valid/ready width narrower. It accepts one `width_in_p`-bit word and emits it as up to `width_in_p/width_out_p` consecutive `width_out_p`-bit beats. It supports a selectable beat order and a per-word beat count for short words. It sits between wide producers (cache/DMA return paths) and narrow links, and replaces the fixed 2:1 toggling narrower with a buffered, handshaked, generalised block.

---
 rtl/bsg_channel_narrow_pkg.sv | 9 +
 rtl/bsg_channel_narrow_sel.sv | 26 ++
 rtl/bsg_channel_narrow_vr.sv | 95 +++++++++
 3 files changed

// File: rtl/bsg_channel_narrow_pkg.sv
// Shared types for the bsg_channel_narrow_vr width narrower.
package bsg_channel_narrow_pkg;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eSend = 1'b1
  } bsg_channel_narrow_state_e;

endpackage

// File: rtl/bsg_channel_narrow_sel.sv
// Combinational beat-slice mux: picks one width_out_p slice of the held word by beat index.
module bsg_channel_narrow_sel #(
  parameter int width_in_p   = 16,
  parameter int width_out_p  = 8,
  parameter int lsb_to_msb_p = 1,
  localparam int els_lp      = width_in_p / width_out_p,
  localparam int lg_els_lp   = $clog2(els_lp)
) (
  input  logic [width_in_p-1:0]  data_i,
  input  logic [lg_els_lp-1:0]   idx_i,
  output logic [width_out_p-1:0] data_o
);

  logic [width_out_p-1:0] slices [els_lp];

  // Beat order is folded into the slice table so the runtime mux is a plain index.
  for (genvar g = 0; g < els_lp; g++) begin : g_slice
    localparam int src_lp = (lsb_to_msb_p != 0) ? g : (els_lp - 1 - g);
    assign slices[g] = data_i[src_lp*width_out_p +: width_out_p];
  end

  always_comb begin
    data_o = slices[idx_i];
  end

endmodule

// File: rtl/bsg_channel_narrow_vr.sv
// Valid/ready narrower: one wide word in, len+1 narrow beats out, last-beat refill without bubbles.
module bsg_channel_narrow_vr
  import bsg_channel_narrow_pkg::*;
#(
  parameter int width_in_p   = 16,
  parameter int width_out_p  = 8,
  parameter int lsb_to_msb_p = 1,
  localparam int els_lp      = width_in_p / width_out_p,
  localparam int lg_els_lp   = $clog2(els_lp)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [width_in_p-1:0]  data_i,
  input  logic [lg_els_lp-1:0]   len_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_out_p-1:0] data_o,
  output logic                   last_o,
  input  logic                   ready_i
);

  if (width_in_p % width_out_p != 0) begin : g_bad_ratio
    $error("bsg_channel_narrow_vr: width_in_p must be a multiple of width_out_p");
  end
  if (els_lp < 2) begin : g_bad_els
    $error("bsg_channel_narrow_vr: width_in_p/width_out_p must be at least 2");
  end

  bsg_channel_narrow_state_e state_q, state_d;
  logic [width_in_p-1:0] data_q, data_d;
  logic [lg_els_lp-1:0]  cnt_q, cnt_d;
  logic [lg_els_lp-1:0]  len_q, len_d;
  logic [lg_els_lp-1:0]  len_clamp;
  logic                  in_xfer, beat_acc;

  // Clamping only matters when els_lp leaves unused len_i encodings.
  if (els_lp == (1 << lg_els_lp)) begin : g_len_pow2
    assign len_clamp = len_i;
  end else begin : g_len_clamp
    localparam logic [lg_els_lp-1:0] max_len_lp = lg_els_lp'(els_lp - 1);
    assign len_clamp = (len_i > max_len_lp) ? max_len_lp : len_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    v_o      = (state_q == eSend);
    last_o   = v_o && (cnt_q == len_q);
    ready_o  = (state_q == eIdle) || (last_o && ready_i);
    in_xfer  = v_i && ready_o;
    beat_acc = v_o && ready_i;

    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    if (beat_acc) begin
      if (last_o) state_d = eIdle;
      else        cnt_d   = cnt_q + 1'b1;
    end

    // A load overrides the idle transition so the last beat and the refill share a cycle.
    if (in_xfer) begin
      state_d = eSend;
      data_d  = data_i;
      cnt_d   = '0;
      len_d   = len_clamp;
    end
  end

  bsg_channel_narrow_sel #(
    .width_in_p   (width_in_p),
    .width_out_p  (width_out_p),
    .lsb_to_msb_p (lsb_to_msb_p)
  ) sel (
    .data_i (data_q),
    .idx_i  (cnt_q),
    .data_o (data_o)
  );

endmodule
